// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter
// Round-robin arbiter that drives one mesh router output port. Up to N input
// FIFOs compete for the port. The winner is popped combinationally, and its head
// packet is loaded into a one-entry output register that the downstream stage
// drains with popin.
// Optional feature: define ARB_GRANT_CNT_EN to add per-input saturating grant
// counters on the grant_cnt output.
module mesh_port_arbiter #(
  parameter int N       = 5,
  parameter int pckg_sz = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           pndng,
  input  logic [N-1:0]           req,
  input  logic [N*pckg_sz-1:0]   data_in,
  output logic [N-1:0]           pop,
  output logic [pckg_sz-1:0]     data_out,
  output logic                   pndng_out,
  input  logic                   popin,
  output logic [$clog2(N)-1:0]   grant_id
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [N*16-1:0]        grant_cnt
`endif
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        ptr_nxt_s;
  logic [N-1:0]         elig_s;
  logic                 found_s;
  logic [IW-1:0]        win_s;
  logic [IW:0]          scan_sum_s;
  logic [IW-1:0]        scan_idx_s;
  logic                 out_free_s;
  logic                 grant_s;
  logic [pckg_sz-1:0]   sel_data_s;

  assign elig_s     = pndng & req;
  assign out_free_s = (state_r == ST_EMPTY) | popin;
  // reset forces pop low in the same cycle, so a FIFO is never drained while the output is being cleared
  assign grant_s    = reset & out_free_s & found_s;
  assign pndng_out  = (state_r == ST_LOADED);

  // Round-robin scan: first eligible input at or after ptr, wrapping modulo N
  always_comb begin
    found_s    = 1'b0;
    win_s      = {IW{1'b0}};
    scan_sum_s = {(IW+1){1'b0}};
    scan_idx_s = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      scan_sum_s = {1'b0, ptr_r} + (IW+1)'(i);
      if (scan_sum_s >= (IW+1)'(N)) begin
        scan_sum_s = scan_sum_s - (IW+1)'(N);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[IW-1:0];
      if (!found_s && elig_s[scan_idx_s]) begin
        found_s = 1'b1;
        win_s   = scan_idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pop decode and winner data mux; pop is one-hot on a grant, otherwise all zero
  always_comb begin
    pop        = {N{1'b0}};
    sel_data_s = {pckg_sz{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (win_s == IW'(k)) begin
        pop[k]     = grant_s;
        sel_data_s = data_in[k*pckg_sz +: pckg_sz];
      end else begin
        pop[k]     = 1'b0;
      end
    end
  end

  // Pointer advances past the winner, wrapping from N-1 back to 0
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (win_s == IW'(N-1)) begin
      ptr_nxt_s = {IW{1'b0}};
    end else begin
      ptr_nxt_s = win_s + IW'(1);
    end
  end

  // Next state: a grant fills the slot; a drain with no new grant empties it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (found_s) begin
          state_nxt_s = ST_LOADED;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_LOADED: begin
        if (!popin) begin
          state_nxt_s = ST_LOADED;
        end else if (found_s) begin
          state_nxt_s = ST_LOADED;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output slot and pointer; all of them hold unless a grant is issued
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= {pckg_sz{1'b0}};
      grant_id <= {IW{1'b0}};
      ptr_r    <= {IW{1'b0}};
    end else if (grant_s) begin
      data_out <= sel_data_s;
      grant_id <= win_s;
      ptr_r    <= ptr_nxt_s;
    end else begin
      data_out <= data_out;
      grant_id <= grant_id;
      ptr_r    <= ptr_r;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  // Per-input grant counters that saturate at all-ones
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        grant_cnt[k*16 +: 16] <= 16'h0000;
      end else if (pop[k] && (grant_cnt[k*16 +: 16] != 16'hFFFF)) begin
        grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'h0001;
      end else begin
        grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Testbench for mesh_port_arbiter (N=5, pckg_sz=40).
// It drives directed vector tables and a random phase. A cycle model predicts pop.
// A scoreboard queue holds each predicted packet until the DUT presents it.
module tb_mesh_port_arbiter;
  localparam int N = 5;
  localparam int W = 40;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     pndng;
  logic [N-1:0]     req;
  logic [N*W-1:0]   data_in;
  logic [N-1:0]     pop;
  logic [W-1:0]     data_out;
  logic             pndng_out;
  logic             popin;
  logic [2:0]       grant_id;
`ifdef ARB_GRANT_CNT_EN
  logic [N*16-1:0]  grant_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int seq    = 0;

  // reference model state
  bit               m_loaded;
  logic [2:0]       m_ptr;
  logic [2:0]       m_id;
  logic [W-1:0]     m_data;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   id;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       r;
    logic [4:0] pn;
    logic [4:0] rq;
    logic       pi;
    logic [4:0] exp_pop;
    logic       exp_po;
    logic [2:0] exp_gid;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  mesh_port_arbiter #(.N(N), .pckg_sz(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .req       (req),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .pndng_out (pndng_out),
    .popin     (popin),
    .grant_id  (grant_id)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  function automatic logic [W-1:0] pkt(input int k, input int s);
    pkt = {8'(8'hC0 + k), 16'h5A5A, 16'(s)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model/scoreboard, advance the model.
  task automatic step(input vec_t v, input bit use_exp);
    sb_t        e;
    logic [4:0] elig;
    logic [4:0] ep;
    int         w;
    int         c;
    bit         found;
    bit         free;
    reset = v.r;
    pndng = v.pn;
    req   = v.rq;
    popin = v.pi;
    seq++;
    for (int k = 0; k < N; k++) data_in[k*W +: W] = pkt(k, seq);
    #4;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_data", 64'(data_out), 64'(e.data));
      chk("sb_gid", 64'(grant_id), 64'(e.id));
      chk("sb_valid", 64'(pndng_out), 64'(1));
    end else begin
      chk("hold_valid", 64'(pndng_out), 64'(m_loaded));
      chk("hold_data", 64'(data_out), 64'(m_data));
      chk("hold_gid", 64'(grant_id), 64'(m_id));
    end
    elig  = v.pn & v.rq;
    free  = !m_loaded || v.pi;
    found = 1'b0;
    w     = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(m_ptr) + i) % N;
      if (!found && elig[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    ep = (v.r && free && found) ? 5'(1 << w) : 5'b00000;
    chk("model_pop", 64'(pop), 64'(ep));
    if (use_exp) begin
      chk("vec_pop", 64'(pop), 64'(v.exp_pop));
      chk("vec_pndng_out", 64'(pndng_out), 64'(v.exp_po));
      chk("vec_gid", 64'(grant_id), 64'(v.exp_gid));
    end
    if (!v.r) begin
      m_loaded = 1'b0;
      m_data   = '0;
      m_id     = 3'd0;
      m_ptr    = 3'd0;
      sb_q.delete();
    end else if (ep != 5'b00000) begin
      m_loaded = 1'b1;
      m_data   = pkt(w, seq);
      m_id     = 3'(w);
      m_ptr    = 3'((w + 1) % N);
      e.data   = m_data;
      e.id     = m_id;
      sb_q.push_back(e);
    end else if (m_loaded && v.pi) begin
      m_loaded = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // Directed table: reset with pending load, mid-transfer reset, req filter, drain, wrap
    tbl[0]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b1, 3'd2};
    tbl[1]  = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd0};
    tbl[3]  = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b1, 3'd1};
    tbl[4]  = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 5'b11111, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd0};
    tbl[6]  = '{1'b1, 5'b11111, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd1};
    tbl[7]  = '{1'b1, 5'b11111, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd3};
    tbl[8]  = '{1'b1, 5'b11111, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd1};
    tbl[9]  = '{1'b1, 5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b1, 3'd3};
    tbl[10] = '{1'b1, 5'b11111, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd3};
    tbl[11] = '{1'b1, 5'b10000, 5'b11111, 1'b0, 5'b10000, 1'b0, 3'd3};
    tbl[12] = '{1'b1, 5'b11111, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd4};
    tbl[13] = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd4};

    // Reset and the reset-state check
    reset = 1'b0; pndng = '0; req = '0; popin = 1'b0; data_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #4;
    chk("rst_pndng_out", 64'(pndng_out), 64'(0));
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_pop", 64'(pop), 64'(0));
    @(posedge clk); #1;

    // Single request to input 2 with backpressure
    reset = 1'b1; pndng = 5'b00100; req = 5'b00100; popin = 1'b0;
    data_in[2*W +: W] = 40'hAB_0000_1234;
    #4;
    chk("single_pop", 64'(pop), 64'(5'b00100));
    chk("single_pre_valid", 64'(pndng_out), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("single_data", 64'(data_out), 64'(40'hAB_0000_1234));
      chk("single_valid", 64'(pndng_out), 64'(1));
      chk("single_gid", 64'(grant_id), 64'(2));
      chk("single_pop_after", 64'(pop), 64'(0));
      @(posedge clk); #1;
    end
    m_loaded = 1'b1; m_data = 40'hAB_0000_1234; m_id = 3'd2; m_ptr = 3'd3;

    for (int i = 0; i < 14; i++) step(tbl[i], 1'b1);

    // Fairness: all eligible, popin high, rotating grants
    v = '{1'b0, 5'b11111, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0};
    step(v, 1'b0);
    for (int i = 0; i < 10; i++) begin
      v = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'(1 << (i % 5)), (i > 0), 3'((i == 0) ? 0 : (i - 1) % 5)};
      step(v, 1'b1);
    end

    // Backpressure for 20 cycles, then immediate grant on release
    for (int i = 0; i < 20; i++) begin
      v = '{1'b1, 5'b11111, 5'b11111, 1'b0, 5'b00000, 1'b1, 3'd4};
      step(v, 1'b1);
    end
    v = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd4};
    step(v, 1'b1);
    v = '{1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd0};
    step(v, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      v.r  = ($urandom_range(0, 39) != 0);
      v.pn = 5'($urandom);
      v.rq = 5'($urandom);
      v.pi = 1'($urandom);
      v.exp_pop = 5'b00000; v.exp_po = 1'b0; v.exp_gid = 3'd0;
      step(v, 1'b0);
    end

`ifdef ARB_GRANT_CNT_EN
    // Counter saturation on input 0
    v = '{1'b0, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0};
    step(v, 1'b0);
    reset = 1'b1; pndng = 5'b00001; req = 5'b00001; popin = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt_sat_0", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
    for (int k = 1; k < N; k++) chk("cnt_other", 64'(grant_cnt[k*16 +: 16]), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
